// File: rtl/lsu_load_writeback.sv
// Load-return collector. Holds up to DEPTH outstanding warp loads and
// assembles per-lane return data. Completed loads are written to the
// register file in allocation order, at most one per cycle.

// One load slot: valid flag, destination, lane fill mask and lane data
module lsu_lwb_slot #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  i_alloc,
  input  logic [1:0]                            i_warp,
  input  logic [3:0]                            i_reg,
  input  logic                                  i_wr,
  input  logic [$clog2(NUM_LANES)-1:0]          i_lane,
  input  logic [DATA_WIDTH-1:0]                 i_data,
  input  logic                                  i_clr,
  output logic                                  o_vld,
  output logic [NUM_LANES-1:0]                  o_mask,
  output logic [1:0]                            o_warp,
  output logic [3:0]                            o_reg,
  output logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  o_data
);
  logic                                 r_vld;
  logic [NUM_LANES-1:0]                 r_mask;
  logic [1:0]                           r_warp;
  logic [3:0]                           r_reg;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] r_data;

  // Slot lifecycle: retire frees, alloc claims and clears the mask, responses fill lanes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld  <= 1'b0;
      r_mask <= '0;
      r_warp <= '0;
      r_reg  <= '0;
      r_data <= '0;
    end else begin
      if (i_clr) r_vld <= 1'b0;
      if (i_alloc) begin
        r_vld  <= 1'b1;
        r_mask <= '0;
        r_warp <= i_warp;
        r_reg  <= i_reg;
      end
      if (i_wr) begin
        r_data[i_lane] <= i_data;
        r_mask[i_lane] <= 1'b1;
      end
    end
  end

  assign o_vld  = r_vld;
  assign o_mask = r_mask;
  assign o_warp = r_warp;
  assign o_reg  = r_reg;
  assign o_data = r_data;
endmodule

module lsu_load_writeback #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 8,
  parameter int DEPTH      = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  alloc_valid,
  output logic                                  alloc_ready,
  input  logic [1:0]                            alloc_warp,
  input  logic [3:0]                            alloc_reg,
  output logic [$clog2(DEPTH)-1:0]              alloc_tag,
  input  logic                                  resp_valid,
  input  logic [$clog2(DEPTH)-1:0]              resp_tag,
  input  logic [$clog2(NUM_LANES)-1:0]          resp_lane,
  input  logic [DATA_WIDTH-1:0]                 resp_data,
  output logic                                  reg_write_en,
  output logic [3:0]                            reg_write_addr,
  output logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  reg_write_data,
  output logic [1:0]                            warp_num_write,
  output logic                                  illegal_alloc,
  output logic                                  resp_err,
  output logic [$clog2(DEPTH):0]                pending
);
  localparam int TW = $clog2(DEPTH);

  logic [TW-1:0] r_head;
  logic [TW-1:0] r_tail;
  logic [TW:0]   r_count;

  logic [DEPTH-1:0]                                w_vld;
  logic [DEPTH-1:0][NUM_LANES-1:0]                 w_mask;
  logic [DEPTH-1:0][1:0]                           w_warp;
  logic [DEPTH-1:0][3:0]                           w_reg;
  logic [DEPTH-1:0][NUM_LANES-1:0][DATA_WIDTH-1:0] w_data;

  logic w_alloc_req;
  logic w_alloc_ok;
  logic w_alloc_bad;
  logic w_resp_ok;
  logic w_retire;

  // Ready depends only on registered occupancy; a same-cycle retirement does not free a slot early
  assign alloc_ready = (r_count < (TW+1)'(DEPTH));
  assign alloc_tag   = r_tail;
  assign pending     = r_count;

  // Registers 13-15 are read-only thread/block id registers
  assign w_alloc_req = alloc_valid & alloc_ready;
  assign w_alloc_ok  = w_alloc_req & (alloc_reg < 4'd13);
  assign w_alloc_bad = w_alloc_req & ~(alloc_reg < 4'd13);

  // Accept a lane only into a live slot whose lane is still empty
  assign w_resp_ok = resp_valid & w_vld[resp_tag] & ~w_mask[resp_tag][resp_lane];

  // Only the oldest load may retire, and only once every lane has arrived
  assign w_retire = w_vld[r_head] & (&w_mask[r_head]);

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_slot
      lsu_lwb_slot #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_LANES  (NUM_LANES)
      ) u_slot (
        .clk     (clk),
        .reset   (reset),
        .i_alloc (w_alloc_ok & (r_tail == TW'(g))),
        .i_warp  (alloc_warp),
        .i_reg   (alloc_reg),
        .i_wr    (w_resp_ok & (resp_tag == TW'(g))),
        .i_lane  (resp_lane),
        .i_data  (resp_data),
        .i_clr   (w_retire & (r_head == TW'(g))),
        .o_vld   (w_vld[g]),
        .o_mask  (w_mask[g]),
        .o_warp  (w_warp[g]),
        .o_reg   (w_reg[g]),
        .o_data  (w_data[g])
      );
    end
  endgenerate

  // Circular-buffer pointers and occupancy; power-of-2 depth wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc_ok) r_tail <= r_tail + TW'(1);
      if (w_retire)   r_head <= r_head + TW'(1);
      case ({w_alloc_ok, w_retire})
        2'b10:   r_count <= r_count + (TW+1)'(1);
        2'b01:   r_count <= r_count - (TW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Write port and error pulses; write payload holds its last value between pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_en   <= 1'b0;
      reg_write_addr <= '0;
      warp_num_write <= '0;
      reg_write_data <= '0;
      illegal_alloc  <= 1'b0;
      resp_err       <= 1'b0;
    end else begin
      reg_write_en  <= w_retire;
      illegal_alloc <= w_alloc_bad;
      resp_err      <= resp_valid & ~w_resp_ok;
      if (w_retire) begin
        reg_write_addr <= w_reg[r_head];
        warp_num_write <= w_warp[r_head];
        reg_write_data <= w_data[r_head];
      end
    end
  end
endmodule

// File: doc/lsu_load_writeback.md
# lsu_load_writeback

Load-return collector between the LSU memory-response path and the threads register file write port. It tracks up to DEPTH outstanding warp loads, assembles per-lane return data into 8-lane vectors, and retires completed loads in allocation order. Each retirement is a one-cycle write pulse carrying the warp number, register address and 8 lane words. It is the sole driver of the register file write port.

## Interface
- DATA_WIDTH, 16, lane word width
- NUM_LANES, 8, threads per warp (fixed at 8; lane index 3 bits)
- DEPTH, 4, outstanding load slots (power of 2; tag width log2(DEPTH)=2)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- alloc_valid  in  1  LSU requests a load slot
- alloc_ready  out  1  slot available (count < DEPTH)
- alloc_warp  in  2  destination warp
- alloc_reg  in  4  destination register
- alloc_tag  out  2  slot index granted (= tail pointer), valid when alloc_valid && alloc_ready
- resp_valid  in  1  one lane of returned data
- resp_tag  in  2  slot the lane belongs to
- resp_lane  in  3  lane index 0-7
- resp_data  in  DATA_WIDTH  lane data
- reg_write_en  out  1  register file write strobe
- reg_write_addr  out  4  register file write address
- reg_write_data  out  DATA_WIDTH x 8  lane data, index = lane
- warp_num_write  out  2  register file write warp
- illegal_alloc  out  1  one-cycle pulse: alloc of reg 13-15 rejected
- resp_err  out  1  one-cycle pulse: response dropped
- pending  out  3  occupied slots, 0..DEPTH

## Operation
- Slot state: valid bit, warp, reg, 8-bit lane mask, 8 data words. Circular buffer: head (oldest), tail (next alloc), count.
- Allocation fires when alloc_valid && alloc_ready && alloc_reg < 13: slot[tail] gets valid=1, mask=0, warp, reg; tail+1 mod DEPTH; count+1.
- alloc_valid && alloc_ready && alloc_reg >= 13: no slot consumed, tail unchanged, illegal_alloc pulses next cycle. Registers 13-15 are read-only (threadIdx/blockIdx/blockDim).
- alloc_ready = (count < DEPTH), combinational from registered count only; no same-cycle bypass of a retirement.
- Response accepted when slot[resp_tag].valid and mask[resp_lane]==0: data word stored, mask bit set. Otherwise (unallocated slot or lane already filled) dropped and resp_err pulses next cycle; slot state unchanged.
- Responses may target any slot in any order; lanes in any order.
- Retire: when slot[head].valid and mask==8'hFF, next edge drives reg_write_en=1, reg_write_addr/warp_num_write/reg_write_data from slot[head]; same edge clears slot[head].valid, head+1 mod DEPTH, count-1. Max one retirement per cycle.
- Completed non-head slots wait; in-order retirement guarantees two loads to the same warp/reg land in allocation order.
- Simultaneous alloc and retire in one edge: count unchanged, both pointers advance.
- Response to head slot in the same edge as its retirement cannot occur (retire requires full mask already registered).

## Timing
- Reset (async): head=tail=count=0, all valid/mask clear, reg_write_en=0, reg_write_addr=0, warp_num_write=0, reg_write_data all 0, illegal_alloc=0, resp_err=0, pending=0, alloc_ready=1. Reset mid-operation discards all pending loads with no write pulse.
- Alloc: sampled at edge k; pending and alloc_ready reflect it after edge k.
- Writeback latency: final lane sampled at edge k -> reg_write_en high for the cycle after edge k+1, low after edge k+2 unless next head already complete (back-to-back retirements, one per cycle).
- reg_write_addr, warp_num_write, reg_write_data hold last retired values when reg_write_en=0.
- Freed slot visible on alloc_ready after the retiring edge k+1.
- illegal_alloc, resp_err: registered, high exactly one cycle.

## Test plan
- Reset, alloc warp 2 reg 5 (tag 0), lanes 0-7 with data 16'h0100+lane -> reg_write_en one cycle 2 edges after lane 7, warp_num_write=2, addr=5, data[i]=16'h0100+i; pending 1->0.
- Fill 4 slots (tags 0-3), alloc_ready=0; 5th alloc_valid ignored; complete tag 0 -> alloc_ready=1 after retire edge; next alloc gets tag 0 (wrap).
- Complete tag 1 fully before tag 0 -> no write until tag 0 completes; then two consecutive write pulses, tag 0 then tag 1.
- Alloc reg 14 -> illegal_alloc one cycle, pending stays 0, alloc_tag next alloc still 0.
- Response to unallocated tag 3, and duplicate lane 4 on tag 0 -> resp_err one cycle each; original lane 4 data retained in writeback.
- Assert reset with 3 slots partially filled -> all outputs zero, pending=0, no write pulse; fresh alloc gets tag 0.
